// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS hazard/forwarding controller.
package mips_pkg;

  // Widest register index a shadow entry can hold; narrower indices are zero-extended.
  localparam int unsigned MAX_RA_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic                wr_en;
    logic [MAX_RA_W-1:0] dst;
    logic [MAX_RA_W-1:0] rs;
    logic [MAX_RA_W-1:0] rt;
    logic                is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // True when entry e writes a non-zero register that a used ID source reads.
  function automatic logic src_hit(
    input shadow_entry_t       e,
    input logic                use_rs,
    input logic [MAX_RA_W-1:0] rs,
    input logic                use_rt,
    input logic [MAX_RA_W-1:0] rt
  );
    return e.valid && e.wr_en && (e.dst != '0) &&
           ((use_rs && (e.dst == rs)) || (use_rt && (e.dst == rt)));
  endfunction

endpackage

// File: rtl/mips_fwd_cmp.sv
// Forward-select comparator for one EX operand; the MEM producer beats the WB producer.
module mips_fwd_cmp
  import mips_pkg::*;
(
  input  logic [MAX_RA_W-1:0] i_src,
  input  logic                i_mem_wr,
  input  logic [MAX_RA_W-1:0] i_mem_dst,
  input  logic                i_wb_wr,
  input  logic [MAX_RA_W-1:0] i_wb_dst,
  output logic [1:0]          o_sel_c
);

  always_comb begin
    o_sel_c = FWD_RF;
    if (i_src != '0) begin
      if (i_mem_wr && (i_mem_dst == i_src)) begin
        o_sel_c = FWD_MEM;
      end else if (i_wb_wr && (i_wb_dst == i_src)) begin
        o_sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// MIPS_HAZ_FORWARD_EN selects forwarding; undefined builds the interlock-only controller.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RF_WB_BYPASS = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_id_valid,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_rs,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_rt,
  input  logic                        i_id_use_rs,
  input  logic                        i_id_use_rt,
  input  logic                        i_id_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_id_wr_reg,
  input  logic                        i_id_is_load,
  input  logic                        i_br_taken,
  output logic                        o_pc_stall,
  output logic                        o_ifid_stall,
  output logic                        o_ifid_flush,
  output logic                        o_idex_flush,
  output logic                        o_exmem_flush,
  output logic [1:0]                  o_fwd_a_sel,
  output logic [1:0]                  o_fwd_b_sel,
  output logic [CNT_W-1:0]            o_stall_cnt,
  output logic [CNT_W-1:0]            o_flush_cnt,
  output logic [1:0]                  o_hz_state
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);

  shadow_entry_t       r_ex, r_mem, r_wb;
  shadow_entry_t       w_id_entry;
  hz_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_stall_cnt, r_flush_cnt;
  logic                w_use_rs, w_use_rt;
  logic [MAX_RA_W-1:0] w_rs, w_rt;
  logic                w_hazard, w_flush, w_stall;
  logic                w_unused;

  assign w_use_rs = i_id_valid && i_id_use_rs;
  assign w_use_rt = i_id_valid && i_id_use_rt;
  assign w_rs     = MAX_RA_W'(i_id_rs);
  assign w_rt     = MAX_RA_W'(i_id_rt);

  // Unused sources are recorded as $0 so they can never match a producer.
  always_comb begin
    w_id_entry         = SHADOW_BUBBLE;
    w_id_entry.valid   = i_id_valid;
    w_id_entry.wr_en   = i_id_valid && i_id_wr_en;
    w_id_entry.dst     = (i_id_valid && i_id_wr_en) ? MAX_RA_W'(i_id_wr_reg) : '0;
    w_id_entry.rs      = w_use_rs ? w_rs : '0;
    w_id_entry.rt      = w_use_rt ? w_rt : '0;
    w_id_entry.is_load = i_id_valid && i_id_is_load;
  end

`ifdef MIPS_HAZ_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_hazard = r_ex.is_load && src_hit(r_ex, w_use_rs, w_rs, w_use_rt, w_rt);

  mips_fwd_cmp u_fwd_a (
    .i_src     (r_ex.rs),
    .i_mem_wr  (r_mem.valid && r_mem.wr_en),
    .i_mem_dst (r_mem.dst),
    .i_wb_wr   (r_wb.valid && r_wb.wr_en),
    .i_wb_dst  (r_wb.dst),
    .o_sel_c   (o_fwd_a_sel)
  );

  mips_fwd_cmp u_fwd_b (
    .i_src     (r_ex.rt),
    .i_mem_wr  (r_mem.valid && r_mem.wr_en),
    .i_mem_dst (r_mem.dst),
    .i_wb_wr   (r_wb.valid && r_wb.wr_en),
    .i_wb_dst  (r_wb.dst),
    .o_sel_c   (o_fwd_b_sel)
  );
`else
  // Without forwarding every in-flight producer blocks, except WB when the regfile bypasses.
  assign w_hazard = src_hit(r_ex,  w_use_rs, w_rs, w_use_rt, w_rt) ||
                    src_hit(r_mem, w_use_rs, w_rs, w_use_rt, w_rt) ||
                    ((RF_WB_BYPASS == 0) && src_hit(r_wb, w_use_rs, w_rs, w_use_rt, w_rt));

  assign o_fwd_a_sel = FWD_RF;
  assign o_fwd_b_sel = FWD_RF;
`endif

  assign w_unused = ^{r_wb, r_mem, r_ex, (RF_WB_BYPASS != 0)};

  // A branch is accepted once; the cycle after it is a guaranteed flush shadow.
  assign w_flush = i_reset && i_br_taken && (r_state != HZ_FLUSH);
  assign w_stall = w_hazard && !w_flush;

  assign o_pc_stall    = w_stall;
  assign o_ifid_stall  = w_stall;
  assign o_ifid_flush  = w_flush;
  assign o_idex_flush  = w_stall || w_flush;
  assign o_exmem_flush = w_flush;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_hz_state    = r_state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ex  <= SHADOW_BUBBLE;
      r_mem <= SHADOW_BUBBLE;
      r_wb  <= SHADOW_BUBBLE;
    end else begin
      r_wb  <= r_mem;
      r_mem <= w_flush ? SHADOW_BUBBLE : r_ex;
      r_ex  <= (w_flush || w_stall) ? SHADOW_BUBBLE : w_id_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= HZ_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_RUN, HZ_STALL: begin
        if (w_flush) begin
          w_state_nxt = HZ_FLUSH;
        end else if (w_hazard) begin
          w_state_nxt = HZ_STALL;
        end else begin
          w_state_nxt = HZ_RUN;
        end
      end
      HZ_FLUSH: w_state_nxt = HZ_RUN;
      default:  w_state_nxt = HZ_RUN;
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Scoreboard bench for mips_hazard_unit; expectations follow MIPS_HAZ_FORWARD_EN.
module tb_mips_hazard_unit;

  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;
  localparam logic [1:0]  S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wen;
    logic [4:0] wd;
    logic       ld;
  } ins_t;

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    int          sc;
    int          fc;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b0;
  logic i_id_valid = 1'b0, i_id_use_rs = 1'b0, i_id_use_rt = 1'b0;
  logic i_id_wr_en = 1'b0, i_id_is_load = 1'b0, i_br_taken = 1'b0;
  logic [4:0] i_id_rs = '0, i_id_rt = '0, i_id_wr_reg = '0;
  logic o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush, o_exmem_flush;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel, o_hz_state;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   es = 0;
  int   ef = 0;

  mips_hazard_unit #(.NUM_REGS(32), .CNT_W(CNT_W), .RF_WB_BYPASS(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_id_valid(i_id_valid),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_use_rs(i_id_use_rs),
    .i_id_use_rt(i_id_use_rt), .i_id_wr_en(i_id_wr_en), .i_id_wr_reg(i_id_wr_reg),
    .i_id_is_load(i_id_is_load), .i_br_taken(i_br_taken),
    .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall), .o_ifid_flush(o_ifid_flush),
    .o_idex_flush(o_idex_flush), .o_exmem_flush(o_exmem_flush),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt), .o_hz_state(o_hz_state)
  );

  always #5 i_clk = ~i_clk;

  function automatic ins_t nop();
    return '0;
  endfunction

  function automatic ins_t alu(input logic [4:0] wd, input logic [4:0] rs, input logic [4:0] rt);
    return '{v:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, wen:1'b1, wd:wd, ld:1'b0};
  endfunction

  function automatic ins_t lw(input logic [4:0] wd, input logic [4:0] rs);
    return '{v:1'b1, rs:rs, rt:5'd0, urs:1'b1, urt:1'b0, wen:1'b1, wd:wd, ld:1'b1};
  endfunction

  function automatic logic [10:0] mk(input logic st, input logic fl, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [1:0] s);
    return {st, st, fl, st | fl, fl, fa, fb, s};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_ctl"}, 32'({o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_flush,
               o_exmem_flush, o_fwd_a_sel, o_fwd_b_sel, o_hz_state}), 32'(e.ctl));
      check_eq({e.tag, "_scnt"}, 32'(o_stall_cnt), 32'(e.sc));
      check_eq({e.tag, "_fcnt"}, 32'(o_flush_cnt), 32'(e.fc));
    end
  endtask

  task automatic drive(input ins_t ins, input logic br);
    i_id_valid   = ins.v;
    i_id_rs      = ins.rs;
    i_id_rt      = ins.rt;
    i_id_use_rs  = ins.urs;
    i_id_use_rt  = ins.urt;
    i_id_wr_en   = ins.wen;
    i_id_wr_reg  = ins.wd;
    i_id_is_load = ins.ld;
    i_br_taken   = br;
  endtask

  task automatic expect_now(input string tag, input logic [10:0] ctl, input int sc, input int fc);
    sb.push_back('{tag, ctl, sc, fc});
    sb_compare();
  endtask

  // One pipeline cycle: drive ID, queue the expectation, compare at the falling edge.
  task automatic cyc(input string tag, input ins_t ins, input logic br, input logic st,
                     input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] s, input int sc, input int fc);
    drive(ins, br);
    sb.push_back('{tag, mk(st, fl, fa, fb, s), sc, fc});
    @(negedge i_clk);
    sb_compare();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    drive(nop(), 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    expect_now("reset", '0, 0, 0);
    i_reset = 1'b1;

`ifdef MIPS_HAZ_FORWARD_EN
    cyc("f_lw",    lw(2, 1),        0, 0, 0, 2'b00, 2'b00, S_RUN,   0, 0);
    cyc("f_luse",  alu(5, 2, 6),    0, 1, 0, 2'b00, 2'b00, S_RUN,   0, 0);
    cyc("f_hold",  alu(5, 2, 6),    0, 0, 0, 2'b00, 2'b00, S_STALL, 1, 0);
    cyc("f_wbfwd", nop(),           0, 0, 0, 2'b10, 2'b00, S_RUN,   1, 0);
    cyc("f_add3",  alu(3, 7, 8),    0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_rd1",   alu(9, 10, 3),   0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_rd2",   alu(11, 12, 3),  0, 0, 0, 2'b00, 2'b01, S_RUN,   1, 0);
    cyc("f_far",   nop(),           0, 0, 0, 2'b00, 2'b10, S_RUN,   1, 0);
    cyc("f_w3a",   alu(3, 1, 1),    0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_w3b",   alu(3, 1, 1),    0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_rd3",   alu(13, 3, 0),   0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_prio",  nop(),           0, 0, 0, 2'b01, 2'b00, S_RUN,   1, 0);
    cyc("f_lw4",   lw(4, 1),        0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_brhz",  alu(14, 4, 4),   1, 0, 1, 2'b00, 2'b00, S_RUN,   1, 0);
    cyc("f_fl",    nop(),           1, 0, 0, 2'b00, 2'b00, S_FLUSH, 1, 1);
    cyc("f_run",   nop(),           0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 1);
    cyc("f_lw0",   lw(0, 1),        0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 1);
    cyc("f_r0",    alu(15, 0, 0),   0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 1);
    cyc("f_r0fwd", nop(),           0, 0, 0, 2'b00, 2'b00, S_RUN,   1, 1);
    es = 1; ef = 1;
    cyc("rs_w",    lw(10, 1),       0, 0, 0, 2'b00, 2'b00, S_RUN,   es, ef);
`else
    cyc("i_add4",  alu(4, 1, 2),    0, 0, 0, 2'b00, 2'b00, S_RUN,   0, 0);
    cyc("i_rd4",   alu(5, 4, 6),    0, 1, 0, 2'b00, 2'b00, S_RUN,   0, 0);
    cyc("i_hold1", alu(5, 4, 6),    0, 1, 0, 2'b00, 2'b00, S_STALL, 1, 0);
    cyc("i_hold2", alu(5, 4, 6),    0, 0, 0, 2'b00, 2'b00, S_STALL, 2, 0);
    cyc("i_go",    nop(),           0, 0, 0, 2'b00, 2'b00, S_RUN,   2, 0);
    cyc("i_lw7",   lw(7, 1),        0, 0, 0, 2'b00, 2'b00, S_RUN,   2, 0);
    cyc("i_brhz",  alu(8, 7, 7),    1, 0, 1, 2'b00, 2'b00, S_RUN,   2, 0);
    cyc("i_fl",    nop(),           1, 0, 0, 2'b00, 2'b00, S_FLUSH, 2, 1);
    cyc("i_run",   nop(),           0, 0, 0, 2'b00, 2'b00, S_RUN,   2, 1);
    cyc("i_w0",    alu(0, 1, 2),    0, 0, 0, 2'b00, 2'b00, S_RUN,   2, 1);
    cyc("i_r0",    alu(9, 0, 0),    0, 0, 0, 2'b00, 2'b00, S_RUN,   2, 1);
    es = 2; ef = 1;
    cyc("rs_w",    alu(10, 1, 1),   0, 0, 0, 2'b00, 2'b00, S_RUN,   es, ef);
`endif

    // Reset asserted in the middle of a stall cycle.
    drive(alu(11, 10, 0), 1'b0);
    #3;
    expect_now("rs_stall", mk(1, 0, 2'b00, 2'b00, S_RUN), es, ef);
    i_reset = 1'b0;
    #1;
    expect_now("rs_clr", '0, 0, 0);
    @(posedge i_clk);
    #1;
    drive(nop(), 1'b0);
    i_reset = 1'b1;
    cyc("rs_post", nop(), 0, 0, 0, 2'b00, 2'b00, S_RUN, 0, 0);
    es = 0; ef = 0;

    // Repeated producer/consumer pairs drive stall_cnt into saturation.
    for (int k = 0; k < 16; k++) begin
`ifdef MIPS_HAZ_FORWARD_EN
      cyc("sat_w",  lw(20, 1),      0, 0, 0, 2'b00, 2'b00, S_RUN,   es, ef);
      cyc("sat_r1", alu(21, 20, 0), 0, 1, 0, 2'b00, 2'b00, S_RUN,   es, ef);
      if (es < SAT) es++;
      cyc("sat_r2", alu(21, 20, 0), 0, 0, 0, 2'b00, 2'b00, S_STALL, es, ef);
      cyc("sat_n",  nop(),          0, 0, 0, 2'b10, 2'b00, S_RUN,   es, ef);
`else
      cyc("sat_w",  alu(20, 1, 1),  0, 0, 0, 2'b00, 2'b00, S_RUN,   es, ef);
      cyc("sat_r1", alu(21, 20, 0), 0, 1, 0, 2'b00, 2'b00, S_RUN,   es, ef);
      if (es < SAT) es++;
      cyc("sat_r2", alu(21, 20, 0), 0, 1, 0, 2'b00, 2'b00, S_STALL, es, ef);
      if (es < SAT) es++;
      cyc("sat_r3", alu(21, 20, 0), 0, 0, 0, 2'b00, 2'b00, S_STALL, es, ef);
      cyc("sat_n",  nop(),          0, 0, 0, 2'b00, 2'b00, S_RUN,   es, ef);
`endif
    end
    check_eq("stall_sat", 32'(o_stall_cnt), 32'(SAT));

    // Back-to-back branches: every second one lands in the FLUSH shadow and is ignored.
    for (int k = 0; k < 17; k++) begin
      cyc("br_acc", nop(), 1, 0, 1, 2'b00, 2'b00, S_RUN,   es, ef);
      if (ef < SAT) ef++;
      cyc("br_ign", nop(), 1, 0, 0, 2'b00, 2'b00, S_FLUSH, es, ef);
    end
    check_eq("flush_sat", 32'(o_flush_cnt), 32'(SAT));
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
